// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP datapath blocks.
package mlp_pkg;

  localparam int ACT_W     = 8;
  localparam int W_W       = 8;
  localparam int SCORE_W   = 8;
  localparam int N_CLASSES = 10;

  // Width of one signed product: zero-extended activation times signed weight.
  localparam int PROD_W = ACT_W + 1 + W_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_WB,
    ST_DONE
  } mlp_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/mlp_sat_shift.sv
// Arithmetic right shift of a signed accumulator followed by a clamp into
// the unsigned score range [0, 2**SCORE_W-1].
module mlp_sat_shift
  import mlp_pkg::*;
#(
  parameter int IN_W  = 23,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]    value_in,
  output logic        [SCORE_W-1:0] score_out
);

  logic signed [IN_W-1:0] shifted;

  // Negative values clamp to zero, anything above the score range clamps to all ones.
  always_comb begin
    shifted = value_in >>> SHIFT;
    if (shifted[IN_W-1]) begin
      score_out = '0;
    end else if (|shifted[IN_W-2:SCORE_W]) begin
      score_out = '1;
    end else begin
      score_out = shifted[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/output_layer_mac.sv
// Time-multiplexed MLP output layer: a single MAC walks every output neuron
// over all hidden activations, reading weights from a 1-cycle-latency ROM,
// and writes one saturated score per neuron onto the comparator bus.
// Optional feature macro: OUTPUT_LAYER_BIAS_EN adds a per-neuron bias read
// from ROM words N_OUT*N_IN + j, costing one extra cycle per neuron.
module output_layer_mac
  import mlp_pkg::*;
#(
  parameter int N_IN   = 32,
  parameter int N_OUT  = N_CLASSES,
  parameter int SHIFT  = 7,
  parameter int ADDR_W = clog2(N_OUT * N_IN + N_OUT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN*ACT_W-1:0]      act_in,
  output logic [ADDR_W-1:0]          w_addr,
  input  logic [W_W-1:0]             w_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT*SCORE_W-1:0]   scores
);

  localparam int I_W   = clog2(N_IN + 1);
  localparam int J_W   = (N_OUT > 1) ? clog2(N_OUT) : 1;
  localparam int IDX_W = (N_IN > 1) ? clog2(N_IN) : 1;
  localparam int ACC_W = PROD_W + clog2(N_IN) + 1;

  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

  mlp_state_e state_q, state_d;

  logic [N_IN-1:0][ACT_W-1:0]    act_q, act_d;
  logic [I_W-1:0]                i_q, i_d;
  logic [J_W-1:0]                j_q, j_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [N_OUT-1:0][SCORE_W-1:0] scores_q, scores_d;

  logic [IDX_W-1:0]        act_idx;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  wb_value;
  logic [SCORE_W-1:0]       sat_score;

  // Register all state; reset returns the block to an idle, cleared condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      act_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      scores_q <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      scores_q <= scores_d;
    end
  end

  // Next-state sequencing: MAC runs N_IN+1 cycles so the last ROM word lands before writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (i_q == I_LAST) begin
`ifdef OUTPUT_LAYER_BIAS_EN
          state_d = ST_BIAS;
`else
          state_d = ST_WB;
`endif
        end
      end
      ST_BIAS: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = (j_q == J_LAST) ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The ROM word arriving this cycle belongs to the address issued last cycle, hence act[i-1].
  always_comb begin
    act_idx = IDX_W'(i_q - I_W'(1));
    product = $signed({1'b0, act_q[act_idx]}) * $signed(w_data);
  end

  // Writeback value: the bias is pre-shifted so it moves the final score by exactly its own value.
  always_comb begin
`ifdef OUTPUT_LAYER_BIAS_EN
    wb_value = acc_q + (ACC_W'($signed(w_data)) <<< SHIFT);
`else
    wb_value = acc_q;
`endif
  end

  mlp_sat_shift #(
    .IN_W  (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .value_in  (wb_value),
    .score_out (sat_score)
  );

  // Datapath updates: latch activations, step counters, accumulate, and commit scores only in WB.
  always_comb begin
    act_d    = act_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    scores_d = scores_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          act_d = act_in;
          i_d   = '0;
          j_d   = '0;
          acc_d = '0;
        end
      end
      ST_MAC: begin
        if (i_q != '0) begin
          acc_d = acc_q + ACC_W'(product);
        end
        if (i_q == I_LAST) begin
          i_d = '0;
        end else begin
          i_d = i_q + I_W'(1);
        end
      end
      ST_WB: begin
        scores_d[j_q] = sat_score;
        acc_d         = '0;
        if (j_q != J_LAST) begin
          j_d = j_q + J_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Moore outputs: handshakes follow the state, the ROM address follows the counters.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_addr    = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_MAC: begin
        if (i_q != I_LAST) begin
          w_addr = ADDR_W'(int'(j_q) * N_IN + int'(i_q));
        end
      end
`ifdef OUTPUT_LAYER_BIAS_EN
      ST_BIAS: begin
        w_addr = ADDR_W'(N_OUT * N_IN + int'(j_q));
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign scores = scores_q;

endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac: a behavioural 1-cycle ROM feeds the
// weights, and each scenario carries hand-computed expected scores.
// Define OUTPUT_LAYER_BIAS_EN to exercise the bias variant.
module tb_output_layer_mac;

  localparam int N_IN      = 32;
  localparam int N_OUT     = 10;
  localparam int ADDR_W    = 9;
  localparam int ROM_DEPTH = N_OUT * N_IN + N_OUT;
  localparam int SW        = N_OUT * 8;
  localparam int LIMIT     = 1000;
`ifdef OUTPUT_LAYER_BIAS_EN
  localparam int PER = N_IN + 3;
`else
  localparam int PER = N_IN + 2;
`endif
  localparam int EXP_LAT = N_OUT * PER;

  typedef logic [SW-1:0] vec_t;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*8-1:0]    act_in;
  logic [ADDR_W-1:0]    w_addr;
  logic [7:0]           w_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SW-1:0]        scores;

  logic [7:0] rom [ROM_DEPTH];

  int   errors = 0;
  int   checks = 0;
  vec_t expScores;

  output_layer_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_in    (act_in),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .scores    (scores)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (int'(w_addr) < ROM_DEPTH) w_data <= rom[w_addr];
    else w_data <= 8'h00;
  end

  task automatic checkOutput(input string tag, input vec_t observed, input vec_t expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge in IDLE: hands over one activation vector, then
  // follows the run to out_valid, checking issued ROM addresses and latency.
  task automatic applyStimulus(input logic [7:0] actValue, input string tag);
    int cyc;
    int addrErrs;
    int n;
    int k;
    checkOutput({tag, " in_ready before accept"}, vec_t'(in_ready), vec_t'(1));
    act_in   = {N_IN{actValue}};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc      = 0;
    addrErrs = 0;
    while (cyc < LIMIT) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      n = cyc / PER;
      k = cyc % PER;
      if (k < N_IN && w_addr !== ADDR_W'(n * N_IN + k)) addrErrs++;
      cyc++;
    end
    checkOutput({tag, " latency"}, vec_t'(cyc), vec_t'(EXP_LAT));
    checkOutput({tag, " w_addr sequence errors"}, vec_t'(addrErrs), vec_t'(0));
  endtask

  // Completes the output handshake and checks the return to IDLE.
  task automatic acceptOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " in_ready after accept"}, vec_t'(in_ready), vec_t'(1));
    checkOutput({tag, " out_valid after accept"}, vec_t'(out_valid), vec_t'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    act_in    = '0;
    for (int a = 0; a < ROM_DEPTH; a++) rom[a] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", vec_t'(in_ready), vec_t'(1));
    checkOutput("reset out_valid", vec_t'(out_valid), vec_t'(0));
    checkOutput("reset scores", scores, vec_t'(0));
    checkOutput("reset w_addr", vec_t'(w_addr), vec_t'(0));

    // Acts 4, neuron j weights j+1 -> score j+1
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) rom[j*N_IN+i] = 8'(j + 1);
    for (int j = 0; j < N_OUT; j++) expScores[8*j +: 8] = 8'(j + 1);
    applyStimulus(8'd4, "ramp");
    checkOutput("ramp scores", scores, expScores);

    // Backpressure in DONE with an in_valid pulse that must be ignored
    for (int c = 0; c < 5; c++) begin
      act_in   = {N_IN{8'hFF}};
      in_valid = (c == 2 || c == 3);
      checkOutput("hold out_valid", vec_t'(out_valid), vec_t'(1));
      checkOutput("hold in_ready", vec_t'(in_ready), vec_t'(0));
      checkOutput("hold scores", scores, expScores);
      @(negedge clk);
    end
    in_valid = 1'b0;
    acceptOutput("ramp");
    checkOutput("ramp scores after accept", scores, expScores);
    @(negedge clk);
    checkOutput("pulse not accepted", vec_t'(in_ready), vec_t'(1));

    // Acts 255, weights 127 -> every score saturates high
    for (int a = 0; a < N_OUT * N_IN; a++) rom[a] = 8'd127;
    applyStimulus(8'd255, "sat_hi");
    checkOutput("sat_hi scores", scores, {N_OUT{8'hFF}});
    acceptOutput("sat_hi");

    // Acts 255, weights -1 -> every score clamps to zero
    for (int a = 0; a < N_OUT * N_IN; a++) rom[a] = 8'hFF;
    applyStimulus(8'd255, "sat_lo");
    checkOutput("sat_lo scores", scores, vec_t'(0));
    acceptOutput("sat_lo");

    // Reset in the middle of an inference
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) rom[j*N_IN+i] = 8'(j + 1);
    act_in   = {N_IN{8'd4}};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("mid out_valid", vec_t'(out_valid), vec_t'(0));
    checkOutput("mid scores 0..1", vec_t'(scores[15:0]), vec_t'(16'h0201));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort out_valid", vec_t'(out_valid), vec_t'(0));
    checkOutput("abort in_ready", vec_t'(in_ready), vec_t'(1));
    checkOutput("abort scores", scores, vec_t'(0));

    // Fresh inference after abort: acts 8, weights j-3 -> score max(0, 2*(j-3))
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) rom[j*N_IN+i] = 8'(j - 3);
    for (int j = 0; j < N_OUT; j++) expScores[8*j +: 8] = (j <= 3) ? 8'd0 : 8'(2 * (j - 3));
    applyStimulus(8'd8, "after_abort");
    checkOutput("after_abort scores", scores, expScores);
    acceptOutput("after_abort");

`ifdef OUTPUT_LAYER_BIAS_EN
    // Acts 0, bias j = 10*j -> score 10*j
    for (int j = 0; j < N_OUT; j++) rom[N_OUT*N_IN+j] = 8'(10 * j);
    for (int j = 0; j < N_OUT; j++) expScores[8*j +: 8] = 8'(10 * j);
    applyStimulus(8'd0, "bias_ramp");
    checkOutput("bias_ramp scores", scores, expScores);
    acceptOutput("bias_ramp");

    // Negative bias clamps to zero
    for (int j = 0; j < N_OUT; j++) rom[N_OUT*N_IN+j] = 8'hFB;
    applyStimulus(8'd0, "bias_neg");
    checkOutput("bias_neg scores", scores, vec_t'(0));
    acceptOutput("bias_neg");
`else
    // Nonzero bias words must have no effect without the bias feature
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) rom[j*N_IN+i] = 8'(j + 1);
    for (int j = 0; j < N_OUT; j++) rom[N_OUT*N_IN+j] = 8'd50;
    for (int j = 0; j < N_OUT; j++) expScores[8*j +: 8] = 8'(j + 1);
    applyStimulus(8'd4, "no_bias");
    checkOutput("no_bias scores", scores, expScores);
    acceptOutput("no_bias");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
